// File: rtl/reg_file_sb.sv
// Register file with write/ENTRY bypass and a pending-result scoreboard.
// Pending bits track registers waiting on a long-latency write-back; an operand read of one raises stall.
module reg_file_sb #(
  parameter int            DW        = 8,
  parameter int            AW        = 3,
  parameter int            ZERO_R0   = 0,
  parameter logic [DW-1:0] ENTRY_RST = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    rd_a,
  input  logic [AW-1:0]    rd_b,
  input  logic             mode,
  input  logic             lea,
  input  logic [DW-1:0]    imm,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [DW-1:0]    wr_data,
  input  logic             issue_en,
  input  logic [AW-1:0]    issue_addr,
  input  logic             entry_we,
  input  logic [DW-1:0]    entry_data,
  output logic [DW-1:0]    rdata_a,
  output logic [DW-1:0]    rdata_b,
  output logic             stall,
  output logic [2**AW-1:0] pend,
  output logic             issue_err
);

  localparam int N = 2**AW;
  localparam bit ZR = (ZERO_R0 != 0);

  logic [DW-1:0] regs_q [N];
  logic [DW-1:0] regs_d [N];
  logic [N-1:0]  pend_q, pend_d;
  logic [DW-1:0] entry_q, entry_d;
  logic          issue_err_q, issue_err_d;

  logic wr_ok, iss_ok, wr_act, entry_act;
  logic hit_a, hit_b, stall_a, stall_b;

  // Bypass paths are gated by rst_n so outputs show pure reset state while held in reset.
  assign wr_act    = wr_en && rst_n;
  assign entry_act = entry_we && rst_n;
  assign wr_ok     = wr_en && !(ZR && wr_addr == '0);
  assign iss_ok    = issue_en && !(ZR && issue_addr == '0);

  always_comb begin
    for (int i = 0; i < N; i++) regs_d[i] = regs_q[i];
    pend_d      = pend_q;
    entry_d     = entry_q;
    issue_err_d = issue_err_q;
    if (wr_ok) begin
      regs_d[wr_addr] = wr_data;
      pend_d[wr_addr] = 1'b0;
    end
    // Set after clear so a same-cycle issue to the written register wins.
    if (iss_ok) begin
      if (pend_q[issue_addr]) issue_err_d = 1'b1;
      pend_d[issue_addr] = 1'b1;
    end
    if (entry_we) entry_d = entry_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) regs_q[i] <= '0;
      pend_q      <= '0;
      entry_q     <= ENTRY_RST;
      issue_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) regs_q[i] <= regs_d[i];
      pend_q      <= pend_d;
      entry_q     <= entry_d;
      issue_err_q <= issue_err_d;
    end
  end

  assign hit_a = wr_act && (wr_addr == rd_a);
  assign hit_b = wr_act && (wr_addr == rd_b);

  always_comb begin
    if (ZR && rd_a == '0) rdata_a = '0;
    else if (hit_a)       rdata_a = wr_data;
    else                  rdata_a = regs_q[rd_a];

    if (mode)                  rdata_b = imm;
    else if (lea)              rdata_b = entry_act ? entry_data : entry_q;
    else if (ZR && rd_b == '0) rdata_b = '0;
    else if (hit_b)            rdata_b = wr_data;
    else                       rdata_b = regs_q[rd_b];
  end

  assign stall_a   = pend_q[rd_a] && !hit_a;
  assign stall_b   = pend_q[rd_b] && !hit_b && !mode && !lea;
  assign stall     = stall_a || stall_b;
  assign pend      = pend_q;
  assign issue_err = issue_err_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: directed scenarios plus random traffic against an array-based model,
// run on a default instance (k=0) and a ZERO_R0=1 instance (k=1) sharing the same stimulus.
module tb_reg_file_sb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] rd_a, rd_b, wr_addr, issue_addr;
  logic       mode, lea, wr_en, issue_en, entry_we;
  logic [7:0] imm, wr_data, entry_data;

  logic [7:0] ra [2];
  logic [7:0] rb [2];
  logic [7:0] pd [2];
  logic       st [2];
  logic       er [2];

  int total = 0;
  int bad   = 0;

  logic [7:0] mreg [2][8];
  logic [7:0] mpend [2];
  logic       merr [2];
  logic [7:0] mentry;

  always #5 clk = ~clk;

  reg_file_sb #(.DW(8), .AW(3), .ZERO_R0(0)) u_dut (
    .clk(clk), .rst_n(rst_n), .rd_a(rd_a), .rd_b(rd_b), .mode(mode), .lea(lea), .imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .entry_we(entry_we), .entry_data(entry_data),
    .rdata_a(ra[0]), .rdata_b(rb[0]), .stall(st[0]), .pend(pd[0]), .issue_err(er[0]));

  reg_file_sb #(.DW(8), .AW(3), .ZERO_R0(1)) u_dut_z (
    .clk(clk), .rst_n(rst_n), .rd_a(rd_a), .rd_b(rd_b), .mode(mode), .lea(lea), .imm(imm),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .issue_en(issue_en),
    .issue_addr(issue_addr), .entry_we(entry_we), .entry_data(entry_data),
    .rdata_a(ra[1]), .rdata_b(rb[1]), .stall(st[1]), .pend(pd[1]), .issue_err(er[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic zero_addr(int k, logic [2:0] a);
    return (k == 1) && (a == 3'd0);
  endfunction

  function automatic logic [7:0] m_read(int k, logic [2:0] a);
    if (zero_addr(k, a))          return 8'h00;
    if (wr_en && wr_addr == a)    return wr_data;
    return mreg[k][a];
  endfunction

  function automatic logic m_busy(int k, logic [2:0] a);
    return mpend[k][a] && !(wr_en && wr_addr == a);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) mreg[k][i] = 8'h00;
      mpend[k] = 8'h00;
      merr[k]  = 1'b0;
    end
    mentry = 8'h00;
  endtask

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      if (issue_en && !zero_addr(k, issue_addr) && mpend[k][issue_addr]) merr[k] = 1'b1;
      if (wr_en && !zero_addr(k, wr_addr)) begin
        mreg[k][wr_addr]  = wr_data;
        mpend[k][wr_addr] = 1'b0;
      end
      if (issue_en && !zero_addr(k, issue_addr)) mpend[k][issue_addr] = 1'b1;
    end
    if (entry_we) mentry = entry_data;
  endtask

  task automatic check_all();
    logic [7:0] eb;
    logic       es;
    for (int k = 0; k < 2; k++) begin
      if (mode)     eb = imm;
      else if (lea) eb = entry_we ? entry_data : mentry;
      else          eb = m_read(k, rd_b);
      es = m_busy(k, rd_a) || (!mode && !lea && m_busy(k, rd_b));
      chk($sformatf("rdata_a[%0d]", k), ra[k], m_read(k, rd_a));
      chk($sformatf("rdata_b[%0d]", k), rb[k], eb);
      chk($sformatf("stall[%0d]", k), st[k], es);
      chk($sformatf("pend[%0d]", k), pd[k], mpend[k]);
      chk($sformatf("issue_err[%0d]", k), er[k], merr[k]);
    end
  endtask

  task automatic idle();
    rd_a = 0; rd_b = 0; mode = 0; lea = 0; imm = 0;
    wr_en = 0; wr_addr = 0; wr_data = 0;
    issue_en = 0; issue_addr = 0; entry_we = 0; entry_data = 0;
  endtask

  task automatic settle();
    #3;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("reset_stall", st[0], 1'b0);
    rst_n = 1'b1;
    tick();

    // ZERO_R0 instance: r0 is never written or pending
    idle(); wr_en = 1; wr_addr = 0; wr_data = 8'hFF; settle(); tick();
    idle(); issue_en = 1; issue_addr = 0; settle(); tick();
    idle(); rd_a = 0; settle();
    chk("z_rdata_a_r0", ra[1], 8'h00);
    chk("z_pend0", pd[1][0], 1'b0);
    chk("z_stall", st[1], 1'b0);
    chk("z_issue_err", er[1], 1'b0);
    chk("main_pend0", pd[0], 8'h01);
    tick();
    idle(); wr_en = 1; wr_addr = 0; wr_data = 8'h00; settle(); tick();

    // Write then read, then same-cycle bypass
    idle(); wr_en = 1; wr_addr = 3; wr_data = 8'h5A; settle(); tick();
    idle(); rd_a = 3; settle();
    chk("read_r3", ra[0], 8'h5A);
    tick();
    idle(); rd_a = 3; wr_en = 1; wr_addr = 3; wr_data = 8'h77; settle();
    chk("bypass_r3", ra[0], 8'h77);
    tick();

    // Port B immediate / ENTRY selection
    idle(); mode = 1; lea = 1; imm = 8'hC3; settle();
    chk("imm_sel", rb[0], 8'hC3);
    tick();
    idle(); entry_we = 1; entry_data = 8'h10; settle(); tick();
    idle(); lea = 1; settle();
    chk("entry_read", rb[0], 8'h10);
    entry_we = 1; entry_data = 8'h20; settle();
    chk("entry_bypass", rb[0], 8'h20);
    tick();
    idle(); lea = 1; settle();
    chk("entry_updated", rb[0], 8'h20);
    tick();

    // Scoreboard: issue, stall, clear by write-back
    idle(); issue_en = 1; issue_addr = 5; settle(); tick();
    idle(); rd_b = 5; settle();
    chk("stall_r5", st[0], 1'b1);
    chk("pend_r5", pd[0], 8'h20);
    tick();
    idle(); rd_b = 5; wr_en = 1; wr_addr = 5; wr_data = 8'h44; settle();
    chk("wb_no_stall", st[0], 1'b0);
    chk("wb_bypass_b", rb[0], 8'h44);
    tick();
    idle(); settle();
    chk("pend_cleared", pd[0], 8'h00);
    tick();

    // Same-cycle issue+write: set wins, data written; reissue flags error
    idle(); issue_en = 1; issue_addr = 2; wr_en = 1; wr_addr = 2; wr_data = 8'h11; settle(); tick();
    idle(); rd_b = 2; mode = 1; settle();
    chk("pend_r2", pd[0], 8'h04);
    chk("data_r2", mreg[0][2] == 8'h11 ? 8'h11 : 8'hEE, 8'h11);
    wr_en = 1; wr_addr = 7; wr_data = 8'h00; issue_en = 1; issue_addr = 2; settle(); tick();
    idle(); rd_a = 2; settle();
    chk("r2_value", ra[0], 8'h11);
    chk("issue_err_set", er[0], 1'b1);
    tick();
    idle(); wr_en = 1; wr_addr = 2; wr_data = 8'h01; settle(); tick();
    idle(); settle();
    chk("issue_err_sticky", er[0], 1'b1);
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      rd_a       = 3'($urandom_range(0, 7));
      rd_b       = 3'($urandom_range(0, 7));
      mode       = ($urandom_range(0, 3) == 0);
      lea        = ($urandom_range(0, 3) == 0);
      imm        = 8'($urandom);
      wr_en      = ($urandom_range(0, 2) == 0);
      wr_addr    = 3'($urandom_range(0, 7));
      wr_data    = 8'($urandom);
      issue_en   = ($urandom_range(0, 3) == 0);
      issue_addr = 3'($urandom_range(0, 7));
      entry_we   = ($urandom_range(0, 4) == 0);
      entry_data = 8'($urandom);
      settle();
      tick();
    end

    // Mid-cycle async reset discards everything
    idle(); issue_en = 1; issue_addr = 1; wr_en = 1; wr_addr = 6; wr_data = 8'hAB; settle(); tick();
    idle(); issue_en = 1; issue_addr = 4; entry_we = 1; entry_data = 8'h99; settle(); tick();
    idle(); lea = 1; settle();
    chk("pre_rst_entry", rb[0], 8'h99);
    chk("pre_rst_pend", pd[0] & 8'h12, 8'h12);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_pend", pd[0], 8'h00);
    chk("rst_err", er[0], 1'b0);
    chk("rst_entry", rb[0], 8'h00);
    lea = 0;
    for (int i = 0; i < 8; i++) begin
      rd_a = 3'(i);
      #1;
      chk($sformatf("rst_r%0d", i), ra[0], 8'h00);
    end
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    idle(); wr_en = 1; wr_addr = 6; wr_data = 8'h3C; settle(); tick();
    idle(); rd_a = 6; settle();
    chk("post_rst_write", ra[0], 8'h3C);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
